// File: rtl/pkg_graybin.sv
// rtl/pkg_graybin.sv - shared FIFO side enum and width-generic Gray/binary conversion
package pkg_graybin;

  typedef enum logic {SIDE_WR = 1'b0, SIDE_RD = 1'b1} fifo_side_e;

  localparam int GB_MAXW = 32;

  // Callers zero-extend into GB_MAXW bits and pass their real width in w.
  function automatic logic [GB_MAXW-1:0] bin2gray(input logic [GB_MAXW-1:0] b, input int w);
    logic [GB_MAXW-1:0] g;
    g = '0;
    for (int i = 0; i < GB_MAXW - 1; i++) begin
      if (i < w - 1)
        g[i] = b[i] ^ b[i+1];
      else if (i == w - 1)
        g[i] = b[i];
    end
    if (w == GB_MAXW)
      g[GB_MAXW-1] = b[GB_MAXW-1];
    return g;
  endfunction

  function automatic logic [GB_MAXW-1:0] gray2bin(input logic [GB_MAXW-1:0] g, input int w);
    logic [GB_MAXW-1:0] b;
    b = '0;
    if (w == GB_MAXW)
      b[GB_MAXW-1] = g[GB_MAXW-1];
    for (int i = GB_MAXW - 2; i >= 0; i--) begin
      if (i == w - 1)
        b[i] = g[i];
      else if (i < w - 1)
        b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - WIDTH x STAGES flop chain for crossing a Gray pointer into clk
module sync_ff #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++)
        chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++)
        chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/gray_ptr_ctrl.sv
// rtl/gray_ptr_ctrl.sv - one-side dual-clock FIFO pointer with synchronised remote pointer and flags
module gray_ptr_ctrl
  import pkg_graybin::*;
#(
  parameter int         DEPTH       = 8,
  parameter fifo_side_e SIDE        = SIDE_WR,
  parameter int         SYNC_STAGES = 2,
  parameter int         ALMOST_TH   = 1,
  localparam int        AW          = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic [AW:0]   remote_gptr,
  output logic [AW-1:0] addr,
  output logic [AW:0]   bptr,
  output logic [AW:0]   gptr,
  output logic          flag,
  output logic          almost_flag,
  output logic [AW:0]   level,
  output logic          ovf_err
);

  localparam int  W         = AW + 1;
  localparam logic FLAG_RST = (SIDE == SIDE_RD);

  logic [AW:0] sgptr;
  logic [AW:0] rbin;
  logic [AW:0] bnext;
  logic [AW:0] gnext;
  logic [AW:0] lnext;
  logic        adv;
  logic        flag_next;
  logic        almost_next;

  sync_ff #(
    .WIDTH  (W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (remote_gptr),
    .q     (sgptr)
  );

  // Flags are computed from next-state values so a local inc is reflected at the same edge.
  always_comb begin
    adv         = inc & ~flag;
    rbin        = W'(gray2bin(32'(sgptr), W));
    bnext       = bptr + W'(adv);
    gnext       = W'(bin2gray(32'(bnext), W));
    lnext       = '0;
    flag_next   = 1'b0;
    almost_next = 1'b0;
    if (SIDE == SIDE_WR) begin
      lnext       = bnext - rbin;
      flag_next   = (lnext == W'(DEPTH));
      almost_next = (lnext >= W'(DEPTH - ALMOST_TH));
    end else begin
      lnext       = rbin - bnext;
      flag_next   = (lnext == '0);
      almost_next = (lnext <= W'(ALMOST_TH));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bptr        <= '0;
      gptr        <= '0;
      level       <= '0;
      flag        <= FLAG_RST;
      almost_flag <= FLAG_RST;
      ovf_err     <= 1'b0;
    end else begin
      bptr        <= bnext;
      gptr        <= gnext;
      level       <= lnext;
      flag        <= flag_next;
      almost_flag <= almost_next;
      ovf_err     <= inc & flag;
    end
  end

  assign addr = bptr[AW-1:0];

endmodule

// File: tb/tb_gray_ptr_ctrl.sv
// tb/tb_gray_ptr_ctrl.sv - directed self-checking bench for gray_ptr_ctrl
module tb_gray_ptr_ctrl;
  import pkg_graybin::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic       inc_w8, inc_r8, inc_w2, inc_r2;
  logic [3:0] rg_w8, rg_r8;
  logic [1:0] rg_w2, rg_r2;

  logic [2:0] addr_w8, addr_r8;
  logic [3:0] bptr_w8, gptr_w8, lvl_w8, bptr_r8, gptr_r8, lvl_r8;
  logic       flag_w8, alm_w8, ovf_w8, flag_r8, alm_r8, ovf_r8;
  logic [0:0] addr_w2, addr_r2;
  logic [1:0] bptr_w2, gptr_w2, lvl_w2, bptr_r2, gptr_r2, lvl_r2;
  logic       flag_w2, alm_w2, ovf_w2, flag_r2, alm_r2, ovf_r2;

  gray_ptr_ctrl #(.DEPTH(8), .SIDE(SIDE_WR), .SYNC_STAGES(2), .ALMOST_TH(1)) u_wr8 (
    .clk(clk), .rst_n(rst_n), .inc(inc_w8), .remote_gptr(rg_w8), .addr(addr_w8),
    .bptr(bptr_w8), .gptr(gptr_w8), .flag(flag_w8), .almost_flag(alm_w8),
    .level(lvl_w8), .ovf_err(ovf_w8));

  gray_ptr_ctrl #(.DEPTH(8), .SIDE(SIDE_RD), .SYNC_STAGES(2), .ALMOST_TH(1)) u_rd8 (
    .clk(clk), .rst_n(rst_n), .inc(inc_r8), .remote_gptr(rg_r8), .addr(addr_r8),
    .bptr(bptr_r8), .gptr(gptr_r8), .flag(flag_r8), .almost_flag(alm_r8),
    .level(lvl_r8), .ovf_err(ovf_r8));

  gray_ptr_ctrl #(.DEPTH(2), .SIDE(SIDE_WR), .SYNC_STAGES(3), .ALMOST_TH(1)) u_wr2 (
    .clk(clk), .rst_n(rst_n), .inc(inc_w2), .remote_gptr(rg_w2), .addr(addr_w2),
    .bptr(bptr_w2), .gptr(gptr_w2), .flag(flag_w2), .almost_flag(alm_w2),
    .level(lvl_w2), .ovf_err(ovf_w2));

  gray_ptr_ctrl #(.DEPTH(2), .SIDE(SIDE_RD), .SYNC_STAGES(3), .ALMOST_TH(1)) u_rd2 (
    .clk(clk), .rst_n(rst_n), .inc(inc_r2), .remote_gptr(rg_r2), .addr(addr_r2),
    .bptr(bptr_r2), .gptr(gptr_r2), .flag(flag_r2), .almost_flag(alm_r2),
    .level(lvl_r2), .ovf_err(ovf_r2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    inc_w8 = 0; inc_r8 = 0; inc_w2 = 0; inc_r2 = 0;
    rg_w8 = '0; rg_r8 = '0; rg_w2 = '0; rg_r2 = '0;
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    #1;
  endtask

  logic [3:0] gseq [17] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                            4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
  logic [3:0] bin_remote;
  logic [3:0] prev_g;

  initial begin
    // WR DEPTH=8: fill to full, then a blocked push
    do_reset();
    check("w8_rst_flag", 32'(flag_w8), 32'd0);
    check("w8_rst_alm", 32'(alm_w8), 32'd0);
    check("w8_rst_lvl", 32'(lvl_w8), 32'd0);
    check("w8_rst_gptr", 32'(gptr_w8), 32'd0);
    check("w8_rst_ovf", 32'(ovf_w8), 32'd0);
    check("r8_rst_flag", 32'(flag_r8), 32'd1);
    check("r8_rst_alm", 32'(alm_r8), 32'd1);
    check("r8_rst_lvl", 32'(lvl_r8), 32'd0);
    inc_w8 = 1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("w8_lvl_%0d", i), 32'(lvl_w8), 32'(i));
      check($sformatf("w8_alm_%0d", i), 32'(alm_w8), 32'(i >= 7));
      check($sformatf("w8_flag_%0d", i), 32'(flag_w8), 32'(i == 8));
    end
    check("w8_full_bptr", 32'(bptr_w8), 32'd8);
    check("w8_full_gptr", 32'(gptr_w8), 32'hC);
    check("w8_full_addr", 32'(addr_w8), 32'd0);
    tick();
    check("w8_ovf", 32'(ovf_w8), 32'd1);
    check("w8_ovf_bptr", 32'(bptr_w8), 32'd8);
    inc_w8 = 0;
    tick();
    check("w8_ovf_clr", 32'(ovf_w8), 32'd0);

    // RD DEPTH=8: remote latency and drain to empty
    do_reset();
    rg_r8 = 4'b0010;
    tick();
    check("r8_lat_e1", 32'(flag_r8), 32'd1);
    tick();
    check("r8_lat_e2", 32'(flag_r8), 32'd1);
    tick();
    check("r8_lat_e3", 32'(flag_r8), 32'd0);
    check("r8_lat_lvl", 32'(lvl_r8), 32'd3);
    check("r8_lat_alm", 32'(alm_r8), 32'd0);
    inc_r8 = 1;
    tick();
    check("r8_pop1_lvl", 32'(lvl_r8), 32'd2);
    tick();
    check("r8_pop2_lvl", 32'(lvl_r8), 32'd1);
    check("r8_pop2_alm", 32'(alm_r8), 32'd1);
    tick();
    check("r8_pop3_lvl", 32'(lvl_r8), 32'd0);
    check("r8_pop3_flag", 32'(flag_r8), 32'd1);
    tick();
    check("r8_ovf", 32'(ovf_r8), 32'd1);
    check("r8_ovf_bptr", 32'(bptr_r8), 32'd3);
    inc_r8 = 0;
    tick();
    check("r8_ovf_clr", 32'(ovf_r8), 32'd0);

    // RD Gray sequence: remote kept 8 ahead so the reader never goes empty
    do_reset();
    rg_r8 = 4'hC;
    repeat (4) tick();
    check("r8g_prime", 32'(flag_r8), 32'd0);
    prev_g = gptr_r8;
    for (int k = 0; k < 16; k++) begin
      bin_remote = 4'(k + 8);
      rg_r8 = bin_remote ^ (bin_remote >> 1);
      inc_r8 = 1;
      tick();
      check($sformatf("r8g_gptr_%0d", k + 1), 32'(gptr_r8), 32'(gseq[k+1]));
      check($sformatf("r8g_1bit_%0d", k + 1), 32'($countones(gptr_r8 ^ prev_g)), 32'd1);
      prev_g = gptr_r8;
    end
    inc_r8 = 0;
    check("r8g_wrap_bptr", 32'(bptr_r8), 32'd0);

    // WR at level 7: local push coincides with remote pop reaching rbin
    do_reset();
    inc_w8 = 1;
    repeat (7) tick();
    inc_w8 = 0;
    check("w8s_lvl7", 32'(lvl_w8), 32'd7);
    rg_w8 = 4'b0001;
    tick();
    tick();
    inc_w8 = 1;
    tick();
    inc_w8 = 0;
    check("w8s_lvl", 32'(lvl_w8), 32'd7);
    check("w8s_flag", 32'(flag_w8), 32'd0);
    check("w8s_bptr", 32'(bptr_w8), 32'd8);

    // Asynchronous reset between edges
    do_reset();
    inc_w8 = 1;
    repeat (5) tick();
    inc_w8 = 0;
    check("w8r_lvl5", 32'(lvl_w8), 32'd5);
    #2;
    rst_n = 0;
    #1;
    check("w8r_bptr", 32'(bptr_w8), 32'd0);
    check("w8r_lvl", 32'(lvl_w8), 32'd0);
    check("w8r_gptr", 32'(gptr_w8), 32'd0);
    check("w8r_alm", 32'(alm_w8), 32'd0);
    #1;
    rst_n = 1;
    inc_w8 = 1;
    tick();
    check("w8r_resume1", 32'(bptr_w8), 32'd1);
    tick();
    inc_w8 = 0;
    check("w8r_resume2", 32'(lvl_w8), 32'd2);

    // DEPTH=2, SYNC_STAGES=3
    do_reset();
    check("w2_rst_flag", 32'(flag_w2), 32'd0);
    check("r2_rst_flag", 32'(flag_r2), 32'd1);
    check("r2_rst_alm", 32'(alm_r2), 32'd1);
    inc_w2 = 1;
    tick();
    check("w2_lvl1", 32'(lvl_w2), 32'd1);
    check("w2_alm1", 32'(alm_w2), 32'd1);
    check("w2_flag1", 32'(flag_w2), 32'd0);
    tick();
    check("w2_lvl2", 32'(lvl_w2), 32'd2);
    check("w2_flag2", 32'(flag_w2), 32'd1);
    check("w2_gptr2", 32'(gptr_w2), 32'd3);
    tick();
    check("w2_ovf", 32'(ovf_w2), 32'd1);
    check("w2_ovf_bptr", 32'(bptr_w2), 32'd2);
    inc_w2 = 0;

    rg_r2 = 2'b11;
    for (int e = 1; e <= 4; e++) begin
      tick();
      check($sformatf("r2_lat_e%0d", e), 32'(flag_r2), 32'(e < 4));
    end
    check("r2_lat_lvl", 32'(lvl_r2), 32'd2);
    check("r2_lat_alm", 32'(alm_r2), 32'd0);
    inc_r2 = 1;
    tick();
    check("r2_pop1_lvl", 32'(lvl_r2), 32'd1);
    check("r2_pop1_alm", 32'(alm_r2), 32'd1);
    tick();
    check("r2_pop2_flag", 32'(flag_r2), 32'd1);
    check("r2_pop2_lvl", 32'(lvl_r2), 32'd0);
    tick();
    check("r2_ovf", 32'(ovf_r2), 32'd1);
    check("r2_ovf_bptr", 32'(bptr_r2), 32'd2);
    inc_r2 = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
